// File: rtl/ex_mdu_stage.sv
// EX stage with EX/MEM register, valid/ready handshake and an iterative MULT/DIV unit owning HI/LO.
// Optional EX_FAST_MUL_EN: single-cycle MULT/MULTU; DIV/DIVU stay iterative.
module ex_mdu_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_ex,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_md_op,
  input  logic [XLEN-1:0]   in_alu_out,
  input  logic [XLEN-1:0]   in_src_a,
  input  logic [XLEN-1:0]   in_src_b,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_reg_write,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [XLEN-1:0]   out_store,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              md_busy,
  output logic [XLEN-1:0]   hi,
  output logic [XLEN-1:0]   lo
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic {S_IDLE, S_CALC} state_t;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MFHI  = 3'd5,
    OP_MFLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_t;

  state_t              r_state, w_state_nxt;
  md_op_t              w_op;

  logic                r_out_valid;
  logic [XLEN-1:0]     r_out_result, r_out_store;
  logic [RA_W-1:0]     r_out_rd;
  logic                r_out_rw;
  logic [CTRL_W-1:0]   r_out_ctrl;
  logic [XLEN-1:0]     r_hi, r_lo;

  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_rem, r_quo, r_b, r_a_raw, r_store;
  logic                r_is_div, r_neg_q, r_neg_r, r_div0, r_done;
  logic [RA_W-1:0]     r_rd;
  logic [CTRL_W-1:0]   r_ctrl;

  logic                w_out_free, w_accept, w_start, w_complete, w_load_acc;
  logic                w_is_mul, w_is_div, w_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]     w_abs_a, w_abs_b;
  logic [XLEN:0]       w_mul_sum, w_div_sh, w_div_diff;
  logic                w_div_ok;
  logic [XLEN-1:0]     w_st_rem, w_st_quo, w_fin_rem, w_fin_quo;
  logic [2*XLEN-1:0]   w_prod, w_prod_s, w_new_hilo;
  logic [XLEN-1:0]     w_q, w_r;
  logic [XLEN-1:0]     w_acc_result;
  logic                w_acc_rw;

  assign w_op       = md_op_t'(in_md_op);
  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = (r_state == S_IDLE) && w_out_free && !flush_ex;
  assign w_accept   = in_valid && in_ready;

  assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
  assign w_is_div = (w_op == OP_DIV)  || (w_op == OP_DIVU);
  assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_a_neg  = w_signed && in_src_a[XLEN-1];
  assign w_b_neg  = w_signed && in_src_b[XLEN-1];
  assign w_abs_a  = w_a_neg ? -in_src_a : in_src_a;
  assign w_abs_b  = w_b_neg ? -in_src_b : in_src_b;

`ifdef EX_FAST_MUL_EN
  logic [2*XLEN-1:0] w_ext_a, w_ext_b, w_fast_prod;
  // Sign/zero extension to 2*XLEN lets one truncated multiplier serve both MULT and MULTU.
  assign w_ext_a     = {{XLEN{w_a_neg ? 1'b1 : 1'b0}}, in_src_a};
  assign w_ext_b     = {{XLEN{w_b_neg ? 1'b1 : 1'b0}}, in_src_b};
  assign w_fast_prod = w_ext_a * w_ext_b;
  assign w_start     = w_accept && w_is_div;
`else
  assign w_start     = w_accept && (w_is_mul || w_is_div);
`endif

  assign w_load_acc = w_accept && !w_start;
  assign w_complete = (r_state == S_CALC) && (r_cnt == '0) && w_out_free && !flush_ex;
  assign md_busy    = (r_state == S_CALC);

  // One radix-2 step: shift-add multiply in {rem,quo}, or restoring divide.
  assign w_mul_sum  = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_b} : '0);
  assign w_div_sh   = {r_rem, r_quo[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_ok   = !w_div_diff[XLEN];
  assign w_st_rem   = r_is_div ? (w_div_ok ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0])
                               : w_mul_sum[XLEN:1];
  assign w_st_quo   = r_is_div ? {r_quo[XLEN-2:0], w_div_ok}
                               : {w_mul_sum[0], r_quo[XLEN-1:1]};

  // A completion held by back-pressure already stored its last step; r_done avoids a re-step.
  assign w_fin_rem = r_done ? r_rem : w_st_rem;
  assign w_fin_quo = r_done ? r_quo : w_st_quo;

  assign w_prod     = {w_fin_rem, w_fin_quo};
  assign w_prod_s   = r_neg_q ? -w_prod : w_prod;
  assign w_q        = r_div0 ? '1 : (r_neg_q ? -w_fin_quo : w_fin_quo);
  assign w_r        = r_div0 ? r_a_raw : (r_neg_r ? -w_fin_rem : w_fin_rem);
  assign w_new_hilo = r_is_div ? {w_r, w_q} : w_prod_s;

  always_comb begin
    w_acc_result = in_alu_out;
    w_acc_rw     = in_reg_write;
    case (w_op)
      OP_MFHI: w_acc_result = r_hi;
      OP_MFLO: w_acc_result = r_lo;
`ifdef EX_FAST_MUL_EN
      OP_MULT, OP_MULTU: begin
        w_acc_result = w_fast_prod[XLEN-1:0];
        w_acc_rw     = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_CALC;
      S_CALC: if (flush_ex || w_complete) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_store  <= '0;
      r_out_rd     <= '0;
      r_out_rw     <= 1'b0;
      r_out_ctrl   <= '0;
    end else if (flush_ex) begin
      r_out_valid  <= 1'b0;
    end else if (w_load_acc) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_acc_result;
      r_out_store  <= in_src_b;
      r_out_rd     <= in_rd;
      r_out_rw     <= w_acc_rw;
      r_out_ctrl   <= in_ctrl;
    end else if (w_complete) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_new_hilo[XLEN-1:0];
      r_out_store  <= r_store;
      r_out_rd     <= r_rd;
      r_out_rw     <= 1'b0;
      r_out_ctrl   <= r_ctrl;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_complete) begin
      {r_hi, r_lo} <= w_new_hilo;
    end
`ifdef EX_FAST_MUL_EN
    else if (w_accept && w_is_mul) begin
      {r_hi, r_lo} <= w_fast_prod;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_b      <= '0;
      r_a_raw  <= '0;
      r_store  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_rd     <= '0;
      r_ctrl   <= '0;
    end else if (w_start) begin
      r_cnt    <= CW'(XLEN - 1);
      r_rem    <= '0;
      r_quo    <= w_abs_a;
      r_b      <= w_abs_b;
      r_a_raw  <= in_src_a;
      r_store  <= in_src_b;
      r_is_div <= w_is_div;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_div0   <= (in_src_b == '0);
      r_done   <= 1'b0;
      r_rd     <= in_rd;
      r_ctrl   <= in_ctrl;
    end else if ((r_state == S_CALC) && !flush_ex) begin
      if (r_cnt != '0) begin
        r_rem <= w_st_rem;
        r_quo <= w_st_quo;
        r_cnt <= r_cnt - CW'(1);
      end else if (!r_done) begin
        r_rem  <= w_st_rem;
        r_quo  <= w_st_quo;
        r_done <= 1'b1;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_result    = r_out_result;
  assign out_store     = r_out_store;
  assign out_rd        = r_out_rd;
  assign out_reg_write = r_out_rw;
  assign out_ctrl      = r_out_ctrl;
  assign hi            = r_hi;
  assign lo            = r_lo;

endmodule
